// File: rtl/full_adder_pkg.sv
// full_adder shared definitions: register map, AXI response codes
// and the write/read channel state encodings.
package full_adder_pkg;

    localparam logic [4:0] REG0_OFF   = 5'h00;
    localparam logic [4:0] REG1_OFF   = 5'h04;
    localparam logic [4:0] REG2_OFF   = 5'h08;
    localparam logic [4:0] REG3_OFF   = 5'h0C;
    localparam logic [4:0] SUM_OFF    = 5'h10;
    localparam logic [4:0] STATUS_OFF = 5'h14;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_ADDR,
        WR_HAVE_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/full_adder_core.sv
// full_adder_core: registered a + b + cin, recomputed every cycle;
// the 33-bit result is split into sum and carry-out.
module full_adder_core #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] res_d;
    logic [W:0] res_q;

    assign res_d = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

    // Register the full-width result so sum and carry stay coherent.
    always_ff @(posedge clk_i) begin
        if (rst_i) res_q <= '0;
        else       res_q <= res_d;
    end

    assign sum_o  = res_q[W-1:0];
    assign cout_o = res_q[W];

endmodule

// File: rtl/full_adder_axil_slave.sv
// full_adder_axil_slave: AXI4-Lite register block around full_adder_core.
// Build option FULL_ADDER_SLVERR_EN: SLVERR for RO/unmapped accesses.
module full_adder_axil_slave
    import full_adder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [2:0]          S_AXI_AWPROT,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [2:0]          S_AXI_ARPROT,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    wr_state_t             wr_state_q;
    rd_state_t             rd_state_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic                  arready_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [ADDR_W-1:0]     awaddr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [DATA_W-1:0]     reg_q [4];
    logic [DATA_W-1:0]     sum;
    logic                  cout;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  have_aw, have_w, wr_commit;
    logic [ADDR_W-1:0]     wr_addr, wr_off, rd_off;
    logic [DATA_W-1:0]     wr_data, rd_word;
    logic [DATA_W/8-1:0]   wr_strb;
    logic                  wr_is_rw, rd_ok;
    logic [1:0]            wr_resp, rd_resp;

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID && wready_q;
    assign ar_hs = S_AXI_ARVALID && arready_q;

    assign have_aw   = (wr_state_q == WR_HAVE_ADDR) || aw_hs;
    assign have_w    = (wr_state_q == WR_HAVE_DATA) || w_hs;
    assign wr_commit = (wr_state_q != WR_RESP) && have_aw && have_w;

    assign wr_addr = aw_hs ? S_AXI_AWADDR : awaddr_q;
    assign wr_data = w_hs ? S_AXI_WDATA : wdata_q;
    assign wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;

    assign wr_off   = {wr_addr[ADDR_W-1:2], 2'b00};
    assign rd_off   = {S_AXI_ARADDR[ADDR_W-1:2], 2'b00};
    assign wr_is_rw = wr_off < ADDR_W'(SUM_OFF);

    // Read mux over the live register state; unmapped words read as 0.
    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b1;
        unique case (1'b1)
            rd_off == ADDR_W'(REG0_OFF):   rd_word = reg_q[0];
            rd_off == ADDR_W'(REG1_OFF):   rd_word = reg_q[1];
            rd_off == ADDR_W'(REG2_OFF):   rd_word = reg_q[2];
            rd_off == ADDR_W'(REG3_OFF):   rd_word = reg_q[3];
            rd_off == ADDR_W'(SUM_OFF):    rd_word = sum;
            rd_off == ADDR_W'(STATUS_OFF): rd_word = {{(DATA_W-1){1'b0}}, cout};
            default:                       rd_ok   = 1'b0;
        endcase
    end

`ifdef FULL_ADDER_SLVERR_EN
    assign wr_resp = wr_is_rw ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    assign rd_resp = rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`else
    assign wr_resp = AXI_RESP_OKAY;
    assign rd_resp = AXI_RESP_OKAY;
`endif

    // Write channel: latch AW and W independently, commit, then respond.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXI_RESP_OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            if (aw_hs) awaddr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_state_q == WR_RESP) begin
                if (!bvalid_q) begin
                    bvalid_q <= 1'b1;
                end else if (S_AXI_BREADY) begin
                    bvalid_q   <= 1'b0;
                    wr_state_q <= WR_IDLE;
                    awready_q  <= 1'b1;
                    wready_q   <= 1'b1;
                end
            end else if (wr_commit) begin
                wr_state_q <= WR_RESP;
                awready_q  <= 1'b0;
                wready_q   <= 1'b0;
                bresp_q    <= wr_resp;
            end else if (have_aw) begin
                wr_state_q <= WR_HAVE_ADDR;
                awready_q  <= 1'b0;
                wready_q   <= 1'b1;
            end else if (have_w) begin
                wr_state_q <= WR_HAVE_DATA;
                awready_q  <= 1'b1;
                wready_q   <= 1'b0;
            end else begin
                wr_state_q <= WR_IDLE;
                awready_q  <= 1'b1;
                wready_q   <= 1'b1;
            end
        end
    end

    // Register file: byte-masked update on the commit edge, RO words ignored.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) reg_q[i] <= '0;
        end else if (wr_commit && wr_is_rw) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_strb[b]) reg_q[wr_addr[3:2]][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read channel: capture data at the AR handshake, hold until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state_q <= RD_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_word;
                        rresp_q    <= rd_resp;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (S_AXI_RREADY) begin
                        rd_state_q <= RD_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    full_adder_core #(.W(DATA_W)) u_core (
        .clk_i  (ACLK),
        .rst_i  (ARESET),
        .a_i    (reg_q[0]),
        .b_i    (reg_q[1]),
        .cin_i  (reg_q[2][0]),
        .sum_o  (sum),
        .cout_o (cout)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0],
                         S_AXI_ARADDR[1:0], rd_ok};

endmodule

// File: tb/tb_full_adder_axil_slave.sv
// Bench for full_adder_axil_slave: AXI-Lite master tasks with
// expected responses queued at issue and compared at the handshake.
module tb_full_adder_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    int passed = 0;
    int total  = 0;
    int bcount = 0;

    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [31:0] mdl [4];

    full_adder_axil_slave #(.DATA_W(32), .ADDR_W(5)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (rready)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard: pop expected responses when a handshake is about to occur.
    always @(negedge ACLK) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (BVALID && bready) begin
            bcount++;
            total++;
            if (bq.size() == 0) begin
                $display("FAIL bresp: unexpected response %b, none queued", BRESP);
            end else begin
                eb = bq.pop_front();
                if (BRESP !== eb)
                    $display("FAIL bresp: got %b expected %b", BRESP, eb);
                else passed++;
            end
        end
        if (RVALID && rready) begin
            total++;
            if (rq.size() == 0) begin
                $display("FAIL rdata: unexpected %h, none queued", RDATA);
            end else begin
                er = rq.pop_front();
                if ({RDATA, RRESP} !== er)
                    $display("FAIL rdata: got %h/%b expected %h/%b",
                             RDATA, RRESP, er[33:2], er[1:0]);
                else passed++;
            end
        end
    end

    function automatic logic [32:0] model_add();
        return {1'b0, mdl[0]} + {1'b0, mdl[1]} + {32'b0, mdl[2][0]};
    endfunction

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly,
                             input int w_dly, input int b_hold);
        logic [1:0] er;
        bit aw_done, w_done, aw_h, w_h, got;
        logic [32:0] t;
        er = 2'b00;
`ifdef FULL_ADDER_SLVERR_EN
        if (a >= 5'h10) er = 2'b10;
`endif
        bq.push_back(er);
        if (a < 5'h10)
            for (int b = 0; b < 4; b++)
                if (s[b]) begin
                    t = {1'b0, mdl[a[3:2]]};
                    t[8*b +: 8] = d[8*b +: 8];
                    mdl[a[3:2]] = t[31:0];
                end
        @(posedge ACLK); #1;
        aw_done = 0; w_done = 0;
        for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
            if (c == aw_dly) begin awaddr = a; awvalid = 1; end
            if (c == w_dly) begin wdata = d; wstrb = s; wvalid = 1; end
            @(negedge ACLK);
            aw_h = awvalid && AWREADY;
            w_h  = wvalid && WREADY;
            @(posedge ACLK); #1;
            if (aw_h) begin awvalid = 0; aw_done = 1; end
            if (w_h) begin wvalid = 0; w_done = 1; end
        end
        if (!(aw_done && w_done)) begin
            total++;
            $display("FAIL wr_addr_data: timeout aw=%0b w=%0b", aw_done, w_done);
            awvalid = 0; wvalid = 0;
            void'(bq.pop_back());
            return;
        end
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge ACLK);
            got = BVALID;
            if (!got) begin @(posedge ACLK); #1; end
        end
        if (!got) begin
            total++;
            $display("FAIL wr_bvalid: timeout, got 0 required 1");
            void'(bq.pop_back());
            return;
        end
        for (int h = 0; h < b_hold; h++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            total++;
            if (BVALID !== 1 || AWREADY !== 0 || WREADY !== 0)
                $display("FAIL b_stall: bv/awr/wr got %b%b%b required 100",
                         BVALID, AWREADY, WREADY);
            else passed++;
        end
        @(posedge ACLK); #1; bready = 1;
        @(posedge ACLK); #1; bready = 0;
    endtask

    task automatic axi_read(input logic [4:0] a, input bit ovr,
                            input logic [31:0] ovr_d);
        logic [31:0] ed;
        logic [1:0]  er;
        logic [32:0] s;
        bit hs, got;
        s  = model_add();
        er = 2'b00;
        ed = 32'h0;
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: ed = mdl[a[3:2]];
            3'd4: ed = s[31:0];
            3'd5: ed = {31'b0, s[32]};
            default: begin
                ed = 32'h0;
`ifdef FULL_ADDER_SLVERR_EN
                er = 2'b10;
`endif
            end
        endcase
        if (ovr) ed = ovr_d;
        rq.push_back({ed, er});
        @(posedge ACLK); #1;
        araddr = a; arvalid = 1;
        for (int c = 0; c < 60 && arvalid; c++) begin
            @(negedge ACLK);
            hs = ARREADY;
            @(posedge ACLK); #1;
            if (hs) arvalid = 0;
        end
        if (arvalid) begin
            total++;
            $display("FAIL rd_addr: timeout, arready got 0 required 1");
            arvalid = 0;
            void'(rq.pop_back());
            return;
        end
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge ACLK);
            got = RVALID;
            if (!got) begin @(posedge ACLK); #1; end
        end
        if (!got) begin
            total++;
            $display("FAIL rd_rvalid: timeout, got 0 required 1");
            void'(rq.pop_back());
            return;
        end
        @(posedge ACLK); #1; rready = 1;
        @(posedge ACLK); #1; rready = 0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [42:0] v;
        v = {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA};
        total++;
        if (v !== 43'h0)
            $display("FAIL %s: outputs got %h required 0", tag, v);
        else passed++;
    endtask

    task automatic test_reset();
        ARESET = 1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_all_zero("reset_outputs");
        @(posedge ACLK); #1;
        ARESET = 0;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        total++;
        if (ARREADY !== 1 || AWREADY !== 1 || WREADY !== 1)
            $display("FAIL ready_after_reset: got %b%b%b required 111",
                     ARREADY, AWREADY, WREADY);
        else passed++;
    endtask

    task automatic test_regs();
        for (int i = 0; i < 4; i++)
            axi_write(5'(4*i), 32'(i+1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            axi_read(5'(4*i), 0, 0);
    endtask

    task automatic test_adder();
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(5'h04, 32'h0000_0001, 4'hF, 0, 0, 0);
        axi_write(5'h08, 32'h0000_0001, 4'hF, 0, 0, 0);
        axi_read(5'h10, 1, 32'h0000_0001);
        axi_read(5'h14, 1, 32'h0000_0001);
        axi_write(5'h00, 32'h1234_5678, 4'hF, 0, 0, 0);
        axi_write(5'h08, 32'hFFFF_0000, 4'hF, 0, 0, 0);
        axi_read(5'h10, 1, 32'h1234_5679);
        axi_read(5'h14, 1, 32'h0);
    endtask

    task automatic test_w_before_aw();
        int b0;
        b0 = bcount;
        axi_write(5'h04, 32'hA5A5_A5A5, 4'hF, 3, 0, 0);
        total++;
        if (bcount - b0 !== 1)
            $display("FAIL w_first_bcount: got %0d required 1", bcount - b0);
        else passed++;
        axi_read(5'h04, 1, 32'hA5A5_A5A5);
    endtask

    task automatic test_wstrb();
        axi_write(5'h0C, 32'h0, 4'hF, 0, 0, 0);
        axi_write(5'h0C, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0);
        axi_read(5'h0C, 1, 32'h0000_FF00);
    endtask

    task automatic test_bready_stall();
        fork
            axi_write(5'h08, 32'h0000_0001, 4'hF, 0, 0, 10);
            begin
                repeat (4) @(posedge ACLK);
                axi_read(5'h00, 0, 0);
            end
        join
    endtask

    task automatic test_rw_collision();
        logic [31:0] old;
        old = mdl[3];
        fork
            axi_write(5'h0C, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
            axi_read(5'h0C, 1, old);
        join
        axi_read(5'h0C, 1, 32'hCAFE_F00D);
    endtask

    task automatic test_ro_write();
        axi_write(5'h10, 32'h1357_9BDF, 4'hF, 0, 0, 0);
        axi_read(5'h10, 0, 0);
        axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_read(5'h18, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit hs;
        axi_read(5'h00, 0, 0);
        @(posedge ACLK); #1;
        awaddr = 5'h04; awvalid = 1;
        hs = 0;
        for (int c = 0; c < 20 && !hs; c++) begin
            @(negedge ACLK);
            hs = AWREADY;
            @(posedge ACLK); #1;
        end
        awvalid = 0;
        total++;
        if (!hs) $display("FAIL rst_mid_aw: awready got 0 required 1");
        else passed++;
        ARESET = 1;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check_all_zero("reset_mid_outputs");
        @(posedge ACLK); #1;
        ARESET = 0;
        axi_read(5'h00, 1, 32'h0);
        axi_read(5'h10, 1, 32'h0);
        axi_write(5'h04, 32'h0000_0007, 4'hF, 0, 0, 0);
        axi_read(5'h04, 1, 32'h7);
    endtask

    initial begin
        ARESET = 1;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arvalid = 0; rready = 0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        test_reset();
        test_regs();
        test_adder();
        test_w_before_aw();
        test_wstrb();
        test_bready_stall();
        test_rw_collision();
        test_ro_write();
        test_reset_mid();
        repeat (3) @(posedge ACLK);
        total++;
        if (bq.size() != 0 || rq.size() != 0)
            $display("FAIL drain: pending b=%0d r=%0d required 0",
                     bq.size(), rq.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
